master_tx_port: RTL
===================

Name: master_tx_port

Overview:
- Master-side serial transmitter for the system bus; sits directly upstream of the slave port.
- Accepts a parallel request: read or write, 12-bit address, 8-bit data and a burst descriptor.
- Drives the three serial lanes tx_address, tx_data and tx_burst, with master_valid, read_en and write_en, to the addressed slave.
- Handles burst-write beat sequencing and split pauses signalled by the slave.

Parameters:
ADDR_W, 12, address width shifted on tx_address
DATA_W, 8, data width per beat shifted on tx_data
BLEN_W, 12, burst length field width; the burst word is BLEN_W+1 bits

Ports:
clk  input  1  clock
reset  input  1  reset
start  input  1  one-cycle request pulse; sampled only in IDLE
rd_wr  input  1  1 = read, 0 = write; latched with start
addr_in  input  ADDR_W  transfer start address; latched with start
data_in  input  DATA_W  write beat data; latched with start and on each data_req cycle
burst_en  input  1  1 = burst transfer
burst_len  input  BLEN_W  beat count minus 1; ignored when burst_en = 0
slave_ready  input  1  slave can accept a transfer
split_en  input  1  slave split request
master_valid  output  1  lanes carry valid bits
read_en  output  1  read transfer in progress
write_en  output  1  write transfer in progress
tx_address  output  1  serial address, LSB first
tx_data  output  1  serial write data, LSB first
tx_burst  output  1  serial burst word, LSB first
data_req  output  1  next write beat requested
busy  output  1  not IDLE
tx_done  output  1  one-cycle completion pulse

Behaviour:
- Reset: reset is asynchronous and active-high; clock is clk.
  - All outputs are 0 and the state is IDLE.
  - Reset mid-transfer aborts the transfer immediately; no tx_done is produced.
- Burst word: bit0 = burst_en; bits[12:1] = burst_len, or 0 when burst_en = 0.
  - Total beats = burst_len + 1 for a burst, 1 otherwise.
- IDLE:
  - On start: latch rd_wr, addr_in, data_in and the burst word; clear counters; go to WAIT_RDY.
  - busy rises on the next cycle.
- WAIT_RDY:
  - read_en or write_en is set according to rd_wr; master_valid = 0.
  - When slave_ready = 1, go to HDR on the next edge.
- HDR: exactly 13 cycles, bit_cnt 0..12; master_valid = 1.
  - tx_burst = burst[bit_cnt] for all 13 cycles.
  - tx_address = addr[bit_cnt] while bit_cnt < 12, else 0.
  - Write: tx_data = data[bit_cnt] while bit_cnt < 8, else 0. This is beat 0.
  - Read: tx_data = 0 throughout.
  - Exit after cycle 12:
    - Read → DONE.
    - Write with beats = 1 → DONE.
    - Write burst → DATA with beat_cnt = 1.
  - In the write-burst case, data_req pulses in cycle 12 and data_in is latched at that edge.
- DATA: one write beat is 8 cycles; master_valid = 1; tx_data = data[bit_cnt].
  - In bit 7 of a beat, while beat_cnt < burst_len: data_req = 1 and data_in is latched at that edge.
  - Beats are back-to-back.
  - After the last beat (beat_cnt = burst_len), go to DONE.
- Split: sampled only at a beat boundary, i.e. the last cycle of a beat, or HDR cycle 12 for a write burst.
  - If split_en = 1 there, go to SPLIT_WAIT instead of continuing.
  - Any pending data_req still fires and data_in is still latched.
- SPLIT_WAIT:
  - master_valid = 0; lanes = 0; read_en and write_en are held; beat_cnt is held.
  - Return to DATA, with bit_cnt = 0, on the first cycle with split_en = 0 and slave_ready = 1.
- DONE:
  - One cycle: tx_done = 1, master_valid = 0, read_en = write_en = 0.
  - Then IDLE.
- start while busy = 1 is ignored.
- Counters: bit_cnt is 4 bits. beat_cnt is BLEN_W bits and never wraps, because burst_len ≤ 4095.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package bus_pkg holds:
  - state encoding (IDLE, WAIT_RDY, HDR, DATA, SPLIT_WAIT, DONE);
  - header length constant HDR_BITS = 13;
  - ADDR_W, DATA_W and BLEN_W defaults.
- One natural sub-module: piso_shift (parallel-load, LSB-first shift register, width parameter).
  - Instantiated three times: address, data and burst lanes.

Test Plan:
- Single write, addr=0xA5C, data=0x3B, burst_en=0, slave_ready=1 → WAIT_RDY for 1 cycle. Then 13 cycles of master_valid and write_en. tx_address serially = 0,0,1,1,1,0,1,0,0,1,0,1. tx_data = 1,1,0,1,1,1,0,0. tx_burst all 0. Then tx_done one cycle later, busy drops.
- Single read, addr=0x123 → read_en=1 and tx_data=0 throughout; 13 header cycles; tx_done; data_req never asserted.
- Burst write, burst_len=3, data_in sequence 0x11/0x22/0x33/0x44 → tx_burst = 1 followed by LSB-first 3. data_req fires 3 times: HDR cycle 12 and DATA bit 7 of beats 1 and 2. Total master_valid cycles = 13 + 24 = 37. tx_done once.
- Burst write, burst_len=9, split_en=1 at the end of beat 3 → master_valid=0 while split_en=1. Resume at beat 4 bit 0 after split_en falls. Total data beats = 10 with no beat lost or duplicated.
- slave_ready held 0 for 5 cycles after start → WAIT_RDY holds with master_valid=0; HDR starts the cycle after slave_ready rises.
- reset asserted at HDR cycle 6 → all outputs 0 asynchronously, no tx_done. A start after reset release produces a clean full transfer. A start pulse during busy is ignored.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus master transmit path.
package bus_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int BLEN_W_DEF = 12;
  // Header carries the full burst word, so it is one bit longer than the length field.
  localparam int HDR_BITS   = BLEN_W_DEF + 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_RDY   = 3'd1,
    HDR        = 3'd2,
    DATA       = 3'd3,
    SPLIT_WAIT = 3'd4,
    DONE       = 3'd5
  } tx_state_e;
endpackage

// File: rtl/master_tx_port_if.sv
// Request side and serial bus side of the master transmit port.
interface master_tx_port_if #(
  parameter int ADDR_W = bus_pkg::ADDR_W_DEF,
  parameter int DATA_W = bus_pkg::DATA_W_DEF,
  parameter int BLEN_W = bus_pkg::BLEN_W_DEF
) ();
  logic              start;
  logic              rd_wr;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic              burst_en;
  logic [BLEN_W-1:0] burst_len;
  logic              slave_ready;
  logic              split_en;
  logic              master_valid;
  logic              read_en;
  logic              write_en;
  logic              tx_address;
  logic              tx_data;
  logic              tx_burst;
  logic              data_req;
  logic              busy;
  logic              tx_done;

  modport master (
    input  start, rd_wr, addr_in, data_in, burst_en, burst_len, slave_ready, split_en,
    output master_valid, read_en, write_en, tx_address, tx_data, tx_burst,
           data_req, busy, tx_done
  );

  modport slave (
    output start, rd_wr, addr_in, data_in, burst_en, burst_len, slave_ready, split_en,
    input  master_valid, read_en, write_en, tx_address, tx_data, tx_burst,
           data_req, busy, tx_done
  );
endinterface

// File: rtl/master_tx_port_piso.sv
// Parallel-load LSB-first shift register; idle cycles drain to zero so the lane reads 0.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         q
);
  logic [W-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= {1'b0, sr[W-1:1]};
    else            sr <= '0;
  end

  assign q = sr[0];
endmodule

// File: rtl/master_tx_port.sv
// Master-side serial transmitter: header (addr/data/burst lanes), write-burst beats, split pauses.
module master_tx_port
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BLEN_W = BLEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  master_tx_port_if.master  bus
);
  localparam logic [3:0] HDR_LAST  = 4'(HDR_BITS - 1);
  localparam logic [3:0] BEAT_LAST = 4'(DATA_W - 1);

  tx_state_e         state;
  logic [3:0]        bit_cnt;
  logic [BLEN_W-1:0] beat_cnt;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [BLEN_W:0]   burst_q;
  logic [BLEN_W-1:0] blen_q;

  logic              go_hdr, at_bound, cont, resume;
  logic              d_load, hdr_shift, d_shift;
  logic [DATA_W-1:0] d_din;

  assign blen_q   = burst_q[BLEN_W:1];
  assign go_hdr   = (state == WAIT_RDY) && bus.slave_ready;
  // HDR is beat 0, so one comparison covers both "HDR cycle 12" and "bit 7 of a beat".
  assign at_bound = ((state == HDR) && (bit_cnt == HDR_LAST)) ||
                    ((state == DATA) && (bit_cnt == BEAT_LAST));
  assign cont     = at_bound && !rd_q && (beat_cnt < blen_q);
  assign resume   = (state == SPLIT_WAIT) && !bus.split_en && bus.slave_ready;

  assign hdr_shift = (state == HDR);
  assign d_shift   = (state == HDR) || (state == DATA);
  assign d_load    = go_hdr || (cont && !bus.split_en) || resume;
  assign d_din     = go_hdr ? (rd_q ? '0 : data_q) : (resume ? data_q : bus.data_in);

  piso_shift #(.W(ADDR_W)) u_addr (
    .clk(clk), .reset(reset), .load(go_hdr), .shift(hdr_shift), .din(addr_q), .q(bus.tx_address)
  );
  piso_shift #(.W(DATA_W)) u_data (
    .clk(clk), .reset(reset), .load(d_load), .shift(d_shift), .din(d_din), .q(bus.tx_data)
  );
  piso_shift #(.W(BLEN_W+1)) u_burst (
    .clk(clk), .reset(reset), .load(go_hdr), .shift(hdr_shift), .din(burst_q), .q(bus.tx_burst)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      beat_cnt         <= '0;
      rd_q             <= 1'b0;
      addr_q           <= '0;
      data_q           <= '0;
      burst_q          <= '0;
      bus.master_valid <= 1'b0;
      bus.read_en      <= 1'b0;
      bus.write_en     <= 1'b0;
      bus.data_req     <= 1'b0;
      bus.busy         <= 1'b0;
      bus.tx_done      <= 1'b0;
    end else begin
      bus.data_req <= 1'b0;
      bus.tx_done  <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          rd_q         <= bus.rd_wr;
          addr_q       <= bus.addr_in;
          data_q       <= bus.data_in;
          burst_q      <= bus.burst_en ? {bus.burst_len, 1'b1} : '0;
          bit_cnt      <= '0;
          beat_cnt     <= '0;
          bus.read_en  <= bus.rd_wr;
          bus.write_en <= !bus.rd_wr;
          bus.busy     <= 1'b1;
          state        <= WAIT_RDY;
        end
        WAIT_RDY: if (go_hdr) begin
          bit_cnt          <= '0;
          bus.master_valid <= 1'b1;
          state            <= HDR;
        end
        HDR, DATA: begin
          bit_cnt <= bit_cnt + 4'd1;
          // Registered request: raised one cycle ahead so it is high in the boundary cycle.
          if ((bit_cnt == ((state == HDR) ? HDR_LAST - 4'd1 : BEAT_LAST - 4'd1)) &&
              !rd_q && (beat_cnt < blen_q))
            bus.data_req <= 1'b1;
          if (at_bound) begin
            bit_cnt <= '0;
            if (!cont) begin
              bus.master_valid <= 1'b0;
              bus.read_en      <= 1'b0;
              bus.write_en     <= 1'b0;
              bus.tx_done      <= 1'b1;
              state            <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              data_q   <= bus.data_in;
              if (bus.split_en) begin
                bus.master_valid <= 1'b0;
                state            <= SPLIT_WAIT;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        SPLIT_WAIT: if (resume) begin
          bit_cnt          <= '0;
          bus.master_valid <= 1'b1;
          state            <= DATA;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
